// File: rtl/mx_pkg.sv
// Shared constants and helpers for the MX dot-product datapath: E8M0 scale
// encoding, derived fixed-point widths and FP8 NaN classification.
package mx_pkg;

  localparam logic [7:0] E8M0_BIAS = 8'd127;
  localparam logic [7:0] E8M0_NAN  = 8'hFF;
  localparam int         EXP_OUT_W = 10;

  // Width of one exact element product, LSB = (min subnormal)^2.
  function automatic int prd_w(input int exp_width, input int man_width);
    return 2 * ((1 << exp_width) + man_width);
  endfunction

  function automatic int dot_w(input int exp_width, input int man_width, input int k);
    return prd_w(exp_width, man_width) + $clog2(k);
  endfunction

  // e4m3_spec=1 reserves only the all-ones code for NaN, leaving the rest of
  // the top binade usable as normal values.
  function automatic logic fp8_is_nan(input int unsigned exp_f, input int unsigned man_f,
                                      input int exp_width, input int man_width,
                                      input bit e4m3_spec);
    logic exp_ones;
    logic man_ones;
    exp_ones = (exp_f == ((32'd1 << exp_width) - 32'd1));
    man_ones = (man_f == ((32'd1 << man_width) - 32'd1));
    return e4m3_spec ? (exp_ones && man_ones) : exp_ones;
  endfunction

endpackage

// File: rtl/dot_fp_spec.sv
// Combinational exact dot product of k FP8 pairs in fixed point (LSB equals the
// minimum subnormal squared) plus an any-element-NaN flag.
module dot_fp_spec
  import mx_pkg::*;
#(
  parameter int exp_width = 4,
  parameter int man_width = 3,
  parameter int k         = 32,
  parameter bit e4m3_spec = 1'b1,
  localparam int EL_W  = 1 + exp_width + man_width,
  localparam int DOT_W = dot_w(exp_width, man_width, k)
) (
  input  logic [k*EL_W-1:0]       i_vec_a,
  input  logic [k*EL_W-1:0]       i_vec_b,
  output logic signed [DOT_W-1:0] o_dot,
  output logic                    o_nan
);

  localparam int PRD_W = prd_w(exp_width, man_width);
  localparam int MAG_W = PRD_W / 2;

  // Magnitude in units of the minimum subnormal: subnormals are the bare
  // mantissa, normals carry the hidden one and shift by (exponent - 1).
  function automatic logic [MAG_W-1:0] elem_mag(input logic [EL_W-2:0] bits);
    logic [exp_width-1:0] ex;
    logic [man_width:0]   sig;
    logic [exp_width-1:0] sh;
    ex  = bits[EL_W-2 -: exp_width];
    sig = {(ex != '0), bits[man_width-1:0]};
    sh  = (ex == '0) ? '0 : ex - exp_width'(1);
    return MAG_W'(sig) << sh;
  endfunction

  logic signed [DOT_W-1:0] term [k];
  logic [k-1:0]            nan_vec;

  for (genvar gi = 0; gi < k; gi++) begin : g_lane
    logic [EL_W-1:0]  el_a;
    logic [EL_W-1:0]  el_b;
    logic [PRD_W-1:0] prd_mag;

    assign el_a    = i_vec_a[gi*EL_W +: EL_W];
    assign el_b    = i_vec_b[gi*EL_W +: EL_W];
    assign prd_mag = PRD_W'(elem_mag(el_a[EL_W-2:0])) * PRD_W'(elem_mag(el_b[EL_W-2:0]));
    assign term[gi] = (el_a[EL_W-1] ^ el_b[EL_W-1]) ? -$signed(DOT_W'(prd_mag))
                                                    :  $signed(DOT_W'(prd_mag));
    assign nan_vec[gi] =
        fp8_is_nan(32'(el_a[EL_W-2 -: exp_width]), 32'(el_a[man_width-1:0]),
                   exp_width, man_width, e4m3_spec) |
        fp8_is_nan(32'(el_b[EL_W-2 -: exp_width]), 32'(el_b[man_width-1:0]),
                   exp_width, man_width, e4m3_spec);
  end

  always_comb begin
    o_dot = '0;
    for (int j = 0; j < k; j++) begin
      o_dot = o_dot + term[j];
    end
  end

  assign o_nan = |nan_vec;

endmodule

// File: rtl/mx_dot_acc.sv
// Streaming MX block dot-product accumulator: register beat, exact block dot
// product with combined E8M0 scale, then exponent-aligned group accumulation.
module mx_dot_acc
  import mx_pkg::*;
#(
  parameter int exp_width  = 4,
  parameter int man_width  = 3,
  parameter int k          = 32,
  parameter bit e4m3_spec  = 1'b1,
  parameter int guard_bits = 8,
  localparam int EL_W  = 1 + exp_width + man_width,
  localparam int DOT_W = dot_w(exp_width, man_width, k),
  localparam int ACC_W = DOT_W + guard_bits
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_valid,
  output logic                        o_ready,
  input  logic [k*EL_W-1:0]           i_vec_a,
  input  logic [k*EL_W-1:0]           i_vec_b,
  input  logic [7:0]                  i_scale_a,
  input  logic [7:0]                  i_scale_b,
  input  logic                        i_last,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic signed [ACC_W-1:0]     o_acc,
  output logic signed [EXP_OUT_W-1:0] o_exp,
  output logic                        o_nan,
  output logic                        o_ovf
);

  localparam int SH_W = EXP_OUT_W + 1;
  localparam logic signed [EXP_OUT_W-1:0] BIAS_SUM = EXP_OUT_W'(2 * int'(E8M0_BIAS));
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic advance;

  logic                s0_valid_q, s0_valid_d;
  logic                s0_last_q, s0_last_d;
  logic [k*EL_W-1:0]   s0_vec_a_q, s0_vec_a_d;
  logic [k*EL_W-1:0]   s0_vec_b_q, s0_vec_b_d;
  logic [7:0]          s0_scale_a_q, s0_scale_a_d;
  logic [7:0]          s0_scale_b_q, s0_scale_b_d;

  logic                        s1_valid_q, s1_valid_d;
  logic                        s1_last_q, s1_last_d;
  logic                        s1_nan_q, s1_nan_d;
  logic signed [DOT_W-1:0]     s1_dot_q, s1_dot_d;
  logic signed [EXP_OUT_W-1:0] s1_exp_q, s1_exp_d;

  logic                        grp_open_q, grp_open_d;
  logic signed [ACC_W-1:0]     acc_q, acc_d;
  logic signed [EXP_OUT_W-1:0] acc_exp_q, acc_exp_d;
  logic                        acc_nan_q, acc_nan_d;
  logic                        acc_ovf_q, acc_ovf_d;

  logic                        o_valid_q, o_valid_d;
  logic signed [ACC_W-1:0]     o_acc_q, o_acc_d;
  logic signed [EXP_OUT_W-1:0] o_exp_q, o_exp_d;
  logic                        o_nan_q, o_nan_d;
  logic                        o_ovf_q, o_ovf_d;

  logic signed [DOT_W-1:0]     blk_dot;
  logic                        blk_elem_nan;

  logic signed [ACC_W-1:0]     dot_ext, lhs, rhs, new_acc;
  logic signed [SH_W-1:0]      exp_diff;
  logic signed [EXP_OUT_W-1:0] new_exp;
  logic [ACC_W:0]              sum_wide;
  logic                        sat, new_nan, new_ovf;

  // Anything past ACC_W-1 already leaves only sign bits, i.e. 0 or -1.
  function automatic logic [SH_W-1:0] clamp_shift(input logic signed [SH_W-1:0] d);
    return (d >= SH_W'(ACC_W - 1)) ? SH_W'(ACC_W - 1) : d;
  endfunction

  assign advance = !o_valid_q || i_ready;
  assign o_ready = advance;

  dot_fp_spec #(
    .exp_width (exp_width),
    .man_width (man_width),
    .k         (k),
    .e4m3_spec (e4m3_spec)
  ) u_dot (
    .i_vec_a (s0_vec_a_q),
    .i_vec_b (s0_vec_b_q),
    .o_dot   (blk_dot),
    .o_nan   (blk_elem_nan)
  );

  always_comb begin
    s0_valid_d   = s0_valid_q;
    s0_last_d    = s0_last_q;
    s0_vec_a_d   = s0_vec_a_q;
    s0_vec_b_d   = s0_vec_b_q;
    s0_scale_a_d = s0_scale_a_q;
    s0_scale_b_d = s0_scale_b_q;
    if (advance) begin
      s0_valid_d = i_valid;
      if (i_valid) begin
        s0_last_d    = i_last;
        s0_vec_a_d   = i_vec_a;
        s0_vec_b_d   = i_vec_b;
        s0_scale_a_d = i_scale_a;
        s0_scale_b_d = i_scale_b;
      end
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_last_d  = s1_last_q;
    s1_nan_d   = s1_nan_q;
    s1_dot_d   = s1_dot_q;
    s1_exp_d   = s1_exp_q;
    if (advance) begin
      s1_valid_d = s0_valid_q;
      if (s0_valid_q) begin
        s1_last_d = s0_last_q;
        s1_dot_d  = blk_dot;
        s1_nan_d  = blk_elem_nan || (s0_scale_a_q == E8M0_NAN) || (s0_scale_b_q == E8M0_NAN);
        s1_exp_d  = EXP_OUT_W'(s0_scale_a_q) + EXP_OUT_W'(s0_scale_b_q) - BIAS_SUM;
      end
    end
  end

  // Align to the larger exponent: shift whichever side has the smaller one.
  always_comb begin
    dot_ext  = ACC_W'(s1_dot_q);
    exp_diff = SH_W'(s1_exp_q) - SH_W'(acc_exp_q);
    lhs      = acc_q;
    rhs      = dot_ext;
    new_exp  = acc_exp_q;
    if (exp_diff > 0) begin
      lhs     = acc_q >>> clamp_shift(exp_diff);
      new_exp = s1_exp_q;
    end else begin
      rhs = dot_ext >>> clamp_shift(-exp_diff);
    end
    sum_wide = {lhs[ACC_W-1], lhs} + {rhs[ACC_W-1], rhs};
    sat      = (sum_wide[ACC_W] != sum_wide[ACC_W-1]);
    if (!grp_open_q) begin
      new_acc = dot_ext;
      new_exp = s1_exp_q;
      new_nan = s1_nan_q;
      new_ovf = 1'b0;
    end else begin
      new_acc = sat ? (sum_wide[ACC_W] ? ACC_MIN : ACC_MAX) : sum_wide[ACC_W-1:0];
      new_nan = acc_nan_q || s1_nan_q;
      new_ovf = acc_ovf_q || sat;
    end
  end

  always_comb begin
    grp_open_d = grp_open_q;
    acc_d      = acc_q;
    acc_exp_d  = acc_exp_q;
    acc_nan_d  = acc_nan_q;
    acc_ovf_d  = acc_ovf_q;
    o_valid_d  = o_valid_q;
    o_acc_d    = o_acc_q;
    o_exp_d    = o_exp_q;
    o_nan_d    = o_nan_q;
    o_ovf_d    = o_ovf_q;
    if (advance) begin
      o_valid_d = s1_valid_q && s1_last_q;
      if (s1_valid_q) begin
        grp_open_d = !s1_last_q;
        acc_d      = new_acc;
        acc_exp_d  = new_exp;
        acc_nan_d  = new_nan;
        acc_ovf_d  = new_ovf;
        if (s1_last_q) begin
          o_acc_d = new_acc;
          o_exp_d = new_exp;
          o_nan_d = new_nan;
          o_ovf_d = new_ovf;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_valid_q   <= 1'b0;
      s0_last_q    <= 1'b0;
      s0_vec_a_q   <= '0;
      s0_vec_b_q   <= '0;
      s0_scale_a_q <= '0;
      s0_scale_b_q <= '0;
      s1_valid_q   <= 1'b0;
      s1_last_q    <= 1'b0;
      s1_nan_q     <= 1'b0;
      s1_dot_q     <= '0;
      s1_exp_q     <= '0;
      grp_open_q   <= 1'b0;
      acc_q        <= '0;
      acc_exp_q    <= '0;
      acc_nan_q    <= 1'b0;
      acc_ovf_q    <= 1'b0;
      o_valid_q    <= 1'b0;
      o_acc_q      <= '0;
      o_exp_q      <= '0;
      o_nan_q      <= 1'b0;
      o_ovf_q      <= 1'b0;
    end else begin
      s0_valid_q   <= s0_valid_d;
      s0_last_q    <= s0_last_d;
      s0_vec_a_q   <= s0_vec_a_d;
      s0_vec_b_q   <= s0_vec_b_d;
      s0_scale_a_q <= s0_scale_a_d;
      s0_scale_b_q <= s0_scale_b_d;
      s1_valid_q   <= s1_valid_d;
      s1_last_q    <= s1_last_d;
      s1_nan_q     <= s1_nan_d;
      s1_dot_q     <= s1_dot_d;
      s1_exp_q     <= s1_exp_d;
      grp_open_q   <= grp_open_d;
      acc_q        <= acc_d;
      acc_exp_q    <= acc_exp_d;
      acc_nan_q    <= acc_nan_d;
      acc_ovf_q    <= acc_ovf_d;
      o_valid_q    <= o_valid_d;
      o_acc_q      <= o_acc_d;
      o_exp_q      <= o_exp_d;
      o_nan_q      <= o_nan_d;
      o_ovf_q      <= o_ovf_d;
    end
  end

  assign o_valid = o_valid_q;
  assign o_acc   = o_acc_q;
  assign o_exp   = o_exp_q;
  assign o_nan   = o_nan_q;
  assign o_ovf   = o_ovf_q;

endmodule

// File: tb/tb_mx_dot_acc.sv
// Directed bench for mx_dot_acc: hand-computed block sums, scale alignment,
// NaN, saturation, backpressure and mid-group reset.
module tb_mx_dot_acc;

  localparam int K     = 32;
  localparam int VEC_W = K * 8;
  localparam int ACC_W = 51;

  localparam logic [7:0] P1   = 8'h38;  // +1.0
  localparam logic [7:0] N1   = 8'hB8;  // -1.0
  localparam logic [7:0] MAXE = 8'h7E;  // +448
  localparam logic signed [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    i_valid = 1'b0;
  logic                    o_ready;
  logic [VEC_W-1:0]        i_vec_a = '0;
  logic [VEC_W-1:0]        i_vec_b = '0;
  logic [7:0]              i_scale_a = '0;
  logic [7:0]              i_scale_b = '0;
  logic                    i_last = 1'b0;
  logic                    o_valid;
  logic                    i_ready = 1'b1;
  logic signed [ACC_W-1:0] o_acc;
  logic signed [9:0]       o_exp;
  logic                    o_nan;
  logic                    o_ovf;

  int tests_run = 0;
  int tests_failed = 0;

  bit                      r_got;
  logic signed [ACC_W-1:0] r_acc;
  logic signed [9:0]       r_exp;
  logic                    r_nan;
  logic                    r_ovf;

  mx_dot_acc dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_vec_a   (i_vec_a),
    .i_vec_b   (i_vec_b),
    .i_scale_a (i_scale_a),
    .i_scale_b (i_scale_b),
    .i_last    (i_last),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_acc     (o_acc),
    .o_exp     (o_exp),
    .o_nan     (o_nan),
    .o_ovf     (o_ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  // Inputs change at negedge; o_ready sampled there is what the next posedge sees.
  task automatic send_beat(input logic [VEC_W-1:0] va, input logic [VEC_W-1:0] vb,
                           input logic [7:0] sa, input logic [7:0] sb, input logic last);
    int n;
    @(negedge clk);
    i_valid = 1'b1; i_vec_a = va; i_vec_b = vb;
    i_scale_a = sa; i_scale_b = sb; i_last = last;
    n = 0;
    while (o_ready !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (o_ready !== 1'b1) begin
      tests_run++; tests_failed++;
      $display("FAIL send_timeout: o_ready=%b after %0d cycles, required 1", o_ready, n);
    end
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    i_valid = 1'b0;
    i_last  = 1'b0;
  endtask

  task automatic wait_result();
    r_got = 1'b0;
    for (int n = 0; n < 40 && !r_got; n++) begin
      @(negedge clk);
      if (o_valid === 1'b1) begin
        r_got = 1'b1;
        r_acc = o_acc; r_exp = o_exp; r_nan = o_nan; r_ovf = o_ovf;
        $display("[TB] result acc=%0d exp=%0d nan=%0b ovf=%0b", r_acc, r_exp, r_nan, r_ovf);
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests_run++;
    if (o_valid !== 1'b0 || o_acc !== '0 || o_exp !== '0 || o_nan !== 1'b0 || o_ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: valid=%b acc=%0d exp=%0d nan=%b ovf=%b, required all 0",
               o_valid, o_acc, o_exp, o_nan, o_ovf);
    end
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ready: o_ready=%b o_valid=%b, required 1 and 0", o_ready, o_valid);
    end
  endtask

  task automatic test_single_block();
    send_beat({K{P1}}, {K{P1}}, 8'd127, 8'd127, 1'b1);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      i_valid = 1'b0;
      tests_run++;
      if (o_valid !== (c == 3)) begin
        tests_failed++;
        $display("FAIL single_latency: o_valid=%b at cycle %0d after accept, required %b",
                 o_valid, c, (c == 3));
      end
    end
    $display("[TB] result acc=%0d exp=%0d nan=%0b ovf=%0b", o_acc, o_exp, o_nan, o_ovf);
    tests_run++;
    if (o_acc !== 51'sd8388608 || o_exp !== 10'sd0 || o_nan !== 1'b0 || o_ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_value: acc=%0d exp=%0d nan=%b ovf=%b, required 8388608 0 0 0",
               o_acc, o_exp, o_nan, o_ovf);
    end
  endtask

  task automatic test_two_blocks(input bit reverse);
    send_beat({K{P1}}, {K{P1}}, reverse ? 8'd128 : 8'd127, 8'd127, 1'b0);
    send_beat({K{P1}}, {K{P1}}, reverse ? 8'd127 : 8'd128, 8'd127, 1'b1);
    idle();
    wait_result();
    tests_run++;
    if (!r_got || r_acc !== 51'sd12582912 || r_exp !== 10'sd1 || r_nan !== 1'b0 || r_ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL two_blocks_rev%0d: got=%b acc=%0d exp=%0d nan=%b ovf=%b, required 12582912 1 0 0",
               reverse, r_got, r_acc, r_exp, r_nan, r_ovf);
    end
  endtask

  task automatic test_nan();
    logic [VEC_W-1:0] va;
    va = {K{P1}};
    va[7:0] = 8'h7F;
    send_beat(va, {K{P1}}, 8'd127, 8'd127, 1'b0);
    send_beat({K{P1}}, {K{P1}}, 8'd127, 8'd127, 1'b1);
    idle();
    wait_result();
    tests_run++;
    if (!r_got || r_nan !== 1'b1 || r_acc !== 51'sd142344192) begin
      tests_failed++;
      $display("FAIL nan_element: got=%b nan=%b acc=%0d, required 1 and 142344192", r_got, r_nan, r_acc);
    end
    send_beat({K{P1}}, {K{P1}}, 8'hFF, 8'd127, 1'b1);
    idle();
    wait_result();
    tests_run++;
    if (!r_got || r_nan !== 1'b1 || r_exp !== 10'sd128) begin
      tests_failed++;
      $display("FAIL nan_scale: got=%b nan=%b exp=%0d, required 1 and 128", r_got, r_nan, r_exp);
    end
    va[7:0] = 8'h78;  // 256.0, a normal value when only S.1111.111 is NaN
    send_beat(va, {K{P1}}, 8'd127, 8'd127, 1'b1);
    idle();
    wait_result();
    tests_run++;
    if (!r_got || r_nan !== 1'b0 || r_acc !== 51'sd75235328) begin
      tests_failed++;
      $display("FAIL nan_clean: got=%b nan=%b acc=%0d, required 0 and 75235328", r_got, r_nan, r_acc);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 700; i++) begin
      send_beat({K{MAXE}}, {K{MAXE}}, 8'd127, 8'd127, (i == 699));
    end
    idle();
    wait_result();
    tests_run++;
    if (!r_got || r_acc !== SAT_MAX || r_ovf !== 1'b1 || r_exp !== 10'sd0) begin
      tests_failed++;
      $display("FAIL saturation: got=%b acc=%0d ovf=%b exp=%0d, required %0d 1 0",
               r_got, r_acc, r_ovf, r_exp, SAT_MAX);
    end
  endtask

  task automatic test_far_shift();
    send_beat({K{P1}}, {K{P1}}, 8'd254, 8'd254, 1'b0);
    send_beat({K{N1}}, {K{P1}}, 8'd0, 8'd0, 1'b1);
    idle();
    wait_result();
    tests_run++;
    if (!r_got || r_acc !== 51'sd8388607 || r_exp !== 10'sd254 || r_ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL far_shift_floor: got=%b acc=%0d exp=%0d ovf=%b, required 8388607 254 0",
               r_got, r_acc, r_exp, r_ovf);
    end
    send_beat({K{P1}}, {K{P1}}, 8'd0, 8'd0, 1'b0);
    send_beat({K{P1}}, {K{P1}}, 8'd254, 8'd254, 1'b1);
    idle();
    wait_result();
    tests_run++;
    if (!r_got || r_acc !== 51'sd8388608 || r_exp !== 10'sd254) begin
      tests_failed++;
      $display("FAIL far_shift_acc: got=%b acc=%0d exp=%0d, required 8388608 254", r_got, r_acc, r_exp);
    end
  endtask

  task automatic test_backpressure();
    int n;
    int got;
    @(posedge clk);
    #1 i_ready = 1'b0;
    fork
      begin
        for (int g = 0; g < 4; g++) begin
          send_beat({K{P1}}, {K{P1}}, 8'(128 + g), 8'd127, 1'b1);
        end
        idle();
      end
      begin
        n = 0;
        while (o_valid !== 1'b1 && n < 40) begin
          @(negedge clk);
          n++;
        end
        for (int c = 0; c < 6; c++) begin
          if (c > 0) @(negedge clk);
          tests_run++;
          if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_acc !== 51'sd8388608 || o_exp !== 10'sd1) begin
            tests_failed++;
            $display("FAIL stall_hold: cycle %0d valid=%b ready=%b acc=%0d exp=%0d, required 1 0 8388608 1",
                     c, o_valid, o_ready, o_acc, o_exp);
          end
        end
        @(posedge clk);
        #1 i_ready = 1'b1;
        got = 0;
        for (int b = 0; b < 40 && got < 4; b++) begin
          @(negedge clk);
          if (o_valid === 1'b1) begin
            $display("[TB] result acc=%0d exp=%0d nan=%0b ovf=%0b", o_acc, o_exp, o_nan, o_ovf);
            tests_run++;
            if (o_acc !== 51'sd8388608 || o_exp !== 10'(1 + got)) begin
              tests_failed++;
              $display("FAIL drain_order: result %0d acc=%0d exp=%0d, required 8388608 %0d",
                       got, o_acc, o_exp, 1 + got);
            end
            got++;
          end
        end
        tests_run++;
        if (got != 4) begin
          tests_failed++;
          $display("FAIL drain_count: received %0d results, required 4", got);
        end
      end
    join
  endtask

  task automatic test_reset_mid_group();
    send_beat({K{P1}}, {K{P1}}, 8'd127, 8'd127, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      i_valid = 1'b0;
      tests_run++;
      if (o_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL nonlast_valid: o_valid=%b at cycle %0d, required 0", o_valid, c);
      end
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    send_beat({K{P1}}, {K{P1}}, 8'd127, 8'd127, 1'b1);
    idle();
    wait_result();
    tests_run++;
    if (!r_got || r_acc !== 51'sd8388608 || r_exp !== 10'sd0 || r_nan !== 1'b0 || r_ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_group: got=%b acc=%0d exp=%0d nan=%b ovf=%b, required 8388608 0 0 0",
               r_got, r_acc, r_exp, r_nan, r_ovf);
    end
  endtask

  initial begin
    test_reset();
    test_single_block();
    test_two_blocks(1'b0);
    test_two_blocks(1'b1);
    test_nan();
    test_saturation();
    test_far_shift();
    test_backpressure();
    test_reset_mid_group();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
